// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - decode/hazard-controller interface and operand-type package
package pipeline_hazard_controller_pkg;
  typedef enum logic [1:0] {
    ALU_OP_TYPE_REG  = 2'd0,
    ALU_OP_TYPE_IMM  = 2'd1,
    ALU_OP_TYPE_PC   = 2'd2,
    ALU_OP_TYPE_ZERO = 2'd3
  } ALUOpType;
endpackage

interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  import pipeline_hazard_controller_pkg::*;

  logic                      decValid;
  ALUOpType                  decAluOp1Type;
  ALUOpType                  decAluOp2Type;
  logic                      decIsStore;
  logic                      decIsLoad;
  logic                      decRegWrite;
  logic [REG_ADDR_WIDTH-1:0] decRs1;
  logic [REG_ADDR_WIDTH-1:0] decRs2;
  logic [REG_ADDR_WIDTH-1:0] decRd;
  logic                      exBranchTaken;
  logic                      memBusy;
  logic                      fetchStall;
  logic                      decodeStall;
  logic                      exBubble;
  logic                      flushIF;
  logic                      flushID;
  logic [1:0]                fwdOp1Sel;
  logic [1:0]                fwdOp2Sel;
  logic [1:0]                fwdStoreSel;

  modport master (
    output decValid, decAluOp1Type, decAluOp2Type, decIsStore, decIsLoad, decRegWrite,
    output decRs1, decRs2, decRd, exBranchTaken, memBusy,
    input  fetchStall, decodeStall, exBubble, flushIF, flushID,
    input  fwdOp1Sel, fwdOp2Sel, fwdStoreSel
  );

  modport slave (
    input  decValid, decAluOp1Type, decAluOp2Type, decIsStore, decIsLoad, decRegWrite,
    input  decRs1, decRs2, decRd, exBranchTaken, memBusy,
    output fetchStall, decodeStall, exBubble, flushIF, flushID,
    output fwdOp1Sel, fwdOp2Sel, fwdStoreSel
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall, flush, bubble and forwarding control for the decode stage
// Tracks the EX and MEM occupants; memBusy freezes everything, a branch caught during a freeze is replayed.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  pipeline_hazard_controller_if.slave hz,
  output logic [STALL_CNT_WIDTH-1:0] stallCount
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] MEM_WAIT   = 2'd1;
  localparam logic [1:0] FLUSH_PEND = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic [1:0]                state;
  logic [1:0]                stateNext;
  logic                      exValid;
  logic                      exRegWrite;
  logic                      exIsLoad;
  logic [REG_ADDR_WIDTH-1:0] exRd;
  logic                      memValid;
  logic                      memRegWrite;
  logic [REG_ADDR_WIDTH-1:0] memRd;
  logic [1:0]                fwdOp1Q;
  logic [1:0]                fwdOp2Q;
  logic [1:0]                fwdStoreQ;

  logic reads1;
  logic readsOp2;
  logic readsStore;
  logic reads2;
  logic branchPending;
  logic applyFlush;
  logic loadUse;
  logic stallNow;
  logic squash;

  function automatic logic [1:0] pickFwd(
    input logic                      reads,
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      eValid,
    input logic                      eRegWrite,
    input logic                      eIsLoad,
    input logic [REG_ADDR_WIDTH-1:0] eRd,
    input logic                      mValid,
    input logic                      mRegWrite,
    input logic [REG_ADDR_WIDTH-1:0] mRd
  );
    // The younger producer is checked first so it wins over the older one.
    if (!reads)                                         return FWD_RF;
    if (eValid && eRegWrite && !eIsLoad && (eRd == rs)) return FWD_MEM;
    if (mValid && mRegWrite && (mRd == rs))             return FWD_WB;
    return FWD_RF;
  endfunction

  assign reads1     = hz.decValid && (hz.decAluOp1Type == ALU_OP_TYPE_REG) && (hz.decRs1 != '0);
  assign readsOp2   = hz.decValid && (hz.decAluOp2Type == ALU_OP_TYPE_REG) && (hz.decRs2 != '0);
  assign readsStore = hz.decValid && hz.decIsStore && (hz.decRs2 != '0);
  assign reads2     = readsOp2 || readsStore;

  assign branchPending = (state == FLUSH_PEND);
  assign applyFlush    = !hz.memBusy && (hz.exBranchTaken || branchPending);

  assign loadUse = !hz.memBusy && !applyFlush && exValid && exIsLoad && exRegWrite &&
                   ((reads1 && (hz.decRs1 == exRd)) || (reads2 && (hz.decRs2 == exRd)));

  assign stallNow = hz.memBusy || loadUse;
  assign squash   = applyFlush || loadUse || !hz.decValid;

  assign hz.fetchStall  = !rst && stallNow;
  assign hz.decodeStall = !rst && stallNow;
  assign hz.exBubble    = !rst && loadUse;
  assign hz.flushIF     = !rst && applyFlush;
  assign hz.flushID     = !rst && applyFlush;

  assign hz.fwdOp1Sel   = fwdOp1Q;
  assign hz.fwdOp2Sel   = fwdOp2Q;
  assign hz.fwdStoreSel = fwdStoreQ;

  always_comb begin
    stateNext = RUN;
    if (hz.memBusy) begin
      stateNext = (hz.exBranchTaken || branchPending) ? FLUSH_PEND : MEM_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      exValid     <= 1'b0;
      exRegWrite  <= 1'b0;
      exIsLoad    <= 1'b0;
      exRd        <= '0;
      memValid    <= 1'b0;
      memRegWrite <= 1'b0;
      memRd       <= '0;
      fwdOp1Q     <= FWD_RF;
      fwdOp2Q     <= FWD_RF;
      fwdStoreQ   <= FWD_RF;
      stallCount  <= '0;
    end else begin
      state <= stateNext;

      if (stallNow && (stallCount != {STALL_CNT_WIDTH{1'b1}})) begin
        stallCount <= stallCount + 1'b1;
      end

      if (!hz.memBusy) begin
        memValid    <= exValid;
        memRegWrite <= exRegWrite;
        memRd       <= exRd;

        exValid    <= !squash;
        exRegWrite <= !squash && hz.decRegWrite;
        exIsLoad   <= !squash && hz.decIsLoad;
        exRd       <= hz.decRd;

        if (squash) begin
          fwdOp1Q   <= FWD_RF;
          fwdOp2Q   <= FWD_RF;
          fwdStoreQ <= FWD_RF;
        end else begin
          fwdOp1Q   <= pickFwd(reads1, hz.decRs1, exValid, exRegWrite, exIsLoad, exRd,
                               memValid, memRegWrite, memRd);
          fwdOp2Q   <= pickFwd(readsOp2, hz.decRs2, exValid, exRegWrite, exIsLoad, exRd,
                               memValid, memRegWrite, memRd);
          fwdStoreQ <= pickFwd(readsStore, hz.decRs2, exValid, exRegWrite, exIsLoad, exRd,
                               memValid, memRegWrite, memRd);
        end
      end
    end
  end

endmodule
